traffic_phase_ctrl: RTL and testbench
=====================================

# traffic_phase_ctrl

Parametrised N-way intersection phase controller: generalises the fixed 4-light controller to `N_WAYS` approaches with configurable phase timing. It adds rotating priority for preferential requests, per-way forced red, one-shot green extension and an attention (flashing-yellow) mode. It sits under the top level, driving the per-way light triplets directly from registered outputs.

## Interface
- `N_WAYS`, 4: number of approaches; must be 2 or more.
- `T_STAGGER`, 7: bring-up interval in cycles between successive ways turning red.
- `T_GREEN`, 10: base green duration in cycles.
- `T_YELLOW`, 3: yellow duration in cycles.
- `T_ALLRED`, 2: all-red clearance in cycles.
- `T_EXT`, 5: green extension in cycles, granted by `preset_adds`.
- `FLASH_HALF`, 4: half-period of attention flashing, in cycles.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `attention`  in  1  level input; high requests flashing-yellow mode.
- `preset_adds`  in  N_WAYS  pulse on bit i extends way i's current green.
- `force_reds`  in  N_WAYS  level input; bit i holds way i red and excludes it from rotation.
- `preferentials`  in  N_WAYS  level input; bit i requests priority for the next green.
- `ltfs`  out  N_WAYS×3  per-way `[0:2]` = {red, yellow, green}.
- `phase`  out  3  current state (`phase_e`).
- `active_way`  out  $clog2(N_WAYS)  way owning the current or last green.

## Operation
- States: BRINGUP, GREEN, YELLOW, ALLRED, FLASH.
- Reset values: `ltfs` all 000; `phase` = BRINGUP; `active_way` = 0; counters 0; extension flag clear.
- BRINGUP:
  - Way k turns red (100) at rising edge 1 + k·T_STAGGER after `rst_n` rises; the remaining ways stay 000.
  - T_STAGGER cycles after the last way turns red, go to GREEN with way 0.
  - All inputs are ignored during BRINGUP.
- GREEN:
  - The active way shows 001; all other ways show 100.
  - Exit to YELLOW after T_GREEN cycles, or after T_GREEN+T_EXT cycles if extended.
- Extension: a `preset_adds[active_way]` pulse during GREEN sets the extension flag. Only one extension is granted per green; further pulses are ignored. The flag clears on leaving GREEN.
- Early cut: `force_reds[active_way]` high in GREEN moves to YELLOW on the next edge, independent of the green counter.
- YELLOW: the active way shows 010. Lasts T_YELLOW cycles, then ALLRED.
- ALLRED:
  - All ways show 100 for T_ALLRED cycles.
  - Then GREEN for the way chosen by the arbiter, evaluated on the final ALLRED cycle.
  - If no way is eligible, stay in ALLRED and re-evaluate every cycle.
- Arbiter: eligible ways are those with `force_reds` low.
  - First choice: the lowest rotated index from `active_way`+1 among eligible ways with `preferentials` high.
  - Otherwise: the next eligible way round-robin from `active_way`+1.
  - The current way is chosen again only if it is the sole eligible way.
- FLASH:
  - Entered from GREEN, YELLOW or ALLRED on the edge after `attention` is sampled high.
  - All ways show 010 for FLASH_HALF cycles, then 000 for FLASH_HALF cycles, repeating; the first half shows 010.
  - `attention` low leads to ALLRED with the counter restarted; `active_way` is unchanged.

## Timing
- Outputs are registered and change only on rising `clk` edges, or immediately when `rst_n` is asserted.
- A state entered at edge e holds for exactly its duration D: the next transition occurs at edge e+D.
- Simultaneous events:
  - `attention` has priority over `force_reds`, which has priority over expiry or extension.
  - A `preset_adds` pulse arriving on the last GREEN cycle still extends.
- Counter width is $clog2(max timing + 1). It saturates and never wraps within a state.
- `rst_n` low mid-operation: all outputs return to reset values at once; the bring-up sequence restarts on release.

## Structure
- `traffic_pkg` contains:
  - `phase_e` enum.
  - Light constants: LT_OFF = 000, LT_RED = 100, LT_YEL = 010, LT_GRN = 001.
  - `light_t` typedef for the [0:2] triplet.
- Sub-module `next_way_arbiter`: purely combinational rotating priority over `N_WAYS`. Inputs are `active_way`, the eligibility mask and the preferential mask; outputs are `next_way` and `valid`.

## Test plan
All scenarios use default parameters.
- Bring-up: release `rst_n`, all inputs 0.
  - Way0 goes 100 at edge 1, way1 at 8, way2 at 15, way3 at 22.
  - Way0 goes 001 at edge 29.
- Rotation:
  - Way0 shows 010 at edges 39–41.
  - All ways show 100 at edges 42–43.
  - Way1 shows 001 at edge 44.
- Preference and skip, with `preferentials`=1000 and `force_reds`=0100 during way1 green: the next green is way3, then way0, and way2 never shows green.
- Extension: a `preset_adds[0]` pulse at cycle 3 of way0 green keeps green for 15 cycles. A second pulse has no further effect.
- Attention:
  - `attention` high mid-green gives all ways 010 for 4 cycles, then 000 for 4 cycles, repeating.
  - On release: ALLRED for 2 cycles, then green for the next way.
- All forced plus reset: with `force_reds`=1111, the controller holds all 100 indefinitely. Asserting `rst_n` low mid-YELLOW forces all outputs to 000 immediately.

Source files
------------

// File: rtl/traffic_phase_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : traffic_pkg
// Brief    : Phase encoding, light triplet type and helpers for the N-way
//            intersection phase controller.
// Revision : 1.0
// ============================================================================
package traffic_pkg;

  typedef enum logic [2:0] {
    BRINGUP = 3'd0,
    GREEN   = 3'd1,
    YELLOW  = 3'd2,
    ALLRED  = 3'd3,
    FLASH   = 3'd4
  } phase_e;

  // Index 0 is the red lamp, so the literals read {red, yellow, green}.
  typedef logic [0:2] light_t;

  localparam light_t LT_OFF = 3'b000;
  localparam light_t LT_RED = 3'b100;
  localparam light_t LT_YEL = 3'b010;
  localparam light_t LT_GRN = 3'b001;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage : traffic_pkg
`default_nettype wire

// File: rtl/traffic_phase_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : traffic_phase_ctrl_if
// Brief    : Request inputs and light/phase outputs of the phase controller.
// Revision : 1.0
// ============================================================================
interface traffic_phase_ctrl_if
  import traffic_pkg::*;
#(
  parameter int N_WAYS = 4
);
  localparam int AW_W = $clog2(N_WAYS);

  logic                  attention;
  logic [N_WAYS-1:0]     preset_adds;
  logic [N_WAYS-1:0]     force_reds;
  logic [N_WAYS-1:0]     preferentials;
  light_t [N_WAYS-1:0]   ltfs;
  phase_e                phase;
  logic [AW_W-1:0]       active_way;

  modport master (
    output attention, preset_adds, force_reds, preferentials,
    input  ltfs, phase, active_way
  );

  modport slave (
    input  attention, preset_adds, force_reds, preferentials,
    output ltfs, phase, active_way
  );

endinterface : traffic_phase_ctrl_if
`default_nettype wire

// File: rtl/traffic_phase_ctrl_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : next_way_arbiter
// Brief    : Combinational rotating-priority pick of the next green way.
// Revision : 1.0
// ============================================================================
module next_way_arbiter #(
  parameter int N_WAYS = 4,
  parameter int AW_W   = $clog2(N_WAYS)
) (
  input  logic [AW_W-1:0]   active_way,
  input  logic [N_WAYS-1:0] eligible,
  input  logic [N_WAYS-1:0] preferential,
  output logic [AW_W-1:0]   next_way,
  output logic              valid
);

  logic            w_pref_hit;
  logic            w_rr_hit;
  logic [AW_W-1:0] w_pref_way;
  logic [AW_W-1:0] w_rr_way;
  logic [AW_W-1:0] w_idx;

  // Offset N_WAYS wraps onto the current way; preference never re-picks it,
  // round-robin reaches it only when nothing else is eligible.
  always_comb begin
    w_pref_hit = 1'b0;
    w_rr_hit   = 1'b0;
    w_pref_way = '0;
    w_rr_way   = '0;
    w_idx      = '0;
    for (int d = 1; d <= N_WAYS; d++) begin
      w_idx = AW_W'((int'(active_way) + d) % N_WAYS);
      if (!w_pref_hit && (d < N_WAYS) && eligible[w_idx] && preferential[w_idx]) begin
        w_pref_hit = 1'b1;
        w_pref_way = w_idx;
      end
      if (!w_rr_hit && eligible[w_idx]) begin
        w_rr_hit = 1'b1;
        w_rr_way = w_idx;
      end
    end
  end

  assign next_way = w_pref_hit ? w_pref_way : w_rr_way;
  assign valid    = w_rr_hit;

endmodule : next_way_arbiter
`default_nettype wire

// File: rtl/traffic_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : traffic_phase_ctrl
// Brief    : N-way intersection phase controller with staggered bring-up,
//            rotating priority, forced red, green extension and flash mode.
// Revision : 1.0
// ============================================================================
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int N_WAYS     = 4,
  parameter int T_STAGGER  = 7,
  parameter int T_GREEN    = 10,
  parameter int T_YELLOW   = 3,
  parameter int T_ALLRED   = 2,
  parameter int T_EXT      = 5,
  parameter int FLASH_HALF = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  traffic_phase_ctrl_if.slave  bus
);

  localparam int c_AW    = $clog2(N_WAYS);
  localparam int c_BU_W  = $clog2(N_WAYS + 1);
  localparam int c_T_MAX = max2(max2(max2(T_STAGGER, T_GREEN + T_EXT),
                                     max2(T_YELLOW, T_ALLRED)), FLASH_HALF);
  localparam int c_CNT_W = $clog2(c_T_MAX + 1);

  localparam logic [c_CNT_W-1:0] c_CNT_MAX        = '1;
  localparam logic [c_CNT_W-1:0] c_STAGGER_LAST   = c_CNT_W'(T_STAGGER - 1);
  localparam logic [c_CNT_W-1:0] c_GREEN_LAST     = c_CNT_W'(T_GREEN - 1);
  localparam logic [c_CNT_W-1:0] c_GREEN_EXT_LAST = c_CNT_W'(T_GREEN + T_EXT - 1);
  localparam logic [c_CNT_W-1:0] c_YEL_LAST       = c_CNT_W'(T_YELLOW - 1);
  localparam logic [c_CNT_W-1:0] c_AR_LAST        = c_CNT_W'(T_ALLRED - 1);
  localparam logic [c_CNT_W-1:0] c_FH_LAST        = c_CNT_W'(FLASH_HALF - 1);
  localparam logic [c_BU_W-1:0]  c_BU_DONE        = c_BU_W'(N_WAYS);

  phase_e              r_phase,     w_phase_nxt;
  logic [c_CNT_W-1:0]  r_cnt,       w_cnt_nxt;
  logic [c_AW-1:0]     r_active,    w_active_nxt;
  logic                r_ext,       w_ext_nxt;
  logic                r_flash_off, w_flash_off_nxt;
  logic [c_BU_W-1:0]   r_bu_way,    w_bu_way_nxt;
  light_t [N_WAYS-1:0] r_ltfs,      w_ltfs_nxt;

  logic [c_CNT_W-1:0]  w_cnt_inc;
  logic                w_force_act;
  logic                w_ext_eff;
  logic                w_green_done;
  logic [c_AW-1:0]     w_arb_way;
  logic                w_arb_valid;

  next_way_arbiter #(
    .N_WAYS (N_WAYS),
    .AW_W   (c_AW)
  ) u_arbiter (
    .active_way   (r_active),
    .eligible     (~bus.force_reds),
    .preferential (bus.preferentials),
    .next_way     (w_arb_way),
    .valid        (w_arb_valid)
  );

  assign w_cnt_inc    = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 1'b1;
  assign w_force_act  = bus.force_reds[r_active];
  // A pulse sampled on the final green cycle must still stretch the green.
  assign w_ext_eff    = r_ext | bus.preset_adds[r_active];
  assign w_green_done = (r_cnt == (w_ext_eff ? c_GREEN_EXT_LAST : c_GREEN_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase     <= BRINGUP;
      r_cnt       <= '0;
      r_active    <= '0;
      r_ext       <= 1'b0;
      r_flash_off <= 1'b0;
      r_bu_way    <= '0;
      r_ltfs      <= '0;
    end else begin
      r_phase     <= w_phase_nxt;
      r_cnt       <= w_cnt_nxt;
      r_active    <= w_active_nxt;
      r_ext       <= w_ext_nxt;
      r_flash_off <= w_flash_off_nxt;
      r_bu_way    <= w_bu_way_nxt;
      r_ltfs      <= w_ltfs_nxt;
    end
  end

  always_comb begin
    w_phase_nxt     = r_phase;
    w_cnt_nxt       = w_cnt_inc;
    w_active_nxt    = r_active;
    w_ext_nxt       = r_ext;
    w_flash_off_nxt = r_flash_off;
    w_bu_way_nxt    = r_bu_way;

    unique case (r_phase)
      BRINGUP: begin
        // r_cnt paces the stagger; each zero crossing lights the next way.
        w_cnt_nxt = (r_cnt == c_STAGGER_LAST) ? '0 : w_cnt_inc;
        if (r_cnt == '0) begin
          if (r_bu_way == c_BU_DONE) begin
            w_phase_nxt  = GREEN;
            w_active_nxt = '0;
            w_cnt_nxt    = '0;
          end else begin
            w_bu_way_nxt = r_bu_way + 1'b1;
          end
        end
      end

      GREEN: begin
        if (bus.attention) begin
          w_phase_nxt     = FLASH;
          w_cnt_nxt       = '0;
          w_flash_off_nxt = 1'b0;
          w_ext_nxt       = 1'b0;
        end else if (w_force_act || w_green_done) begin
          w_phase_nxt = YELLOW;
          w_cnt_nxt   = '0;
          w_ext_nxt   = 1'b0;
        end else begin
          w_ext_nxt = w_ext_eff;
        end
      end

      YELLOW: begin
        if (bus.attention) begin
          w_phase_nxt     = FLASH;
          w_cnt_nxt       = '0;
          w_flash_off_nxt = 1'b0;
        end else if (r_cnt == c_YEL_LAST) begin
          w_phase_nxt = ALLRED;
          w_cnt_nxt   = '0;
        end
      end

      ALLRED: begin
        if (bus.attention) begin
          w_phase_nxt     = FLASH;
          w_cnt_nxt       = '0;
          w_flash_off_nxt = 1'b0;
        end else if ((r_cnt >= c_AR_LAST) && w_arb_valid) begin
          w_phase_nxt  = GREEN;
          w_active_nxt = w_arb_way;
          w_cnt_nxt    = '0;
        end
      end

      FLASH: begin
        if (!bus.attention) begin
          w_phase_nxt = ALLRED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_FH_LAST) begin
          w_cnt_nxt       = '0;
          w_flash_off_nxt = ~r_flash_off;
        end
      end

      default: begin
        w_phase_nxt  = BRINGUP;
        w_cnt_nxt    = '0;
        w_bu_way_nxt = '0;
      end
    endcase
  end

  // Lights are decoded from the next state so the registered copy lines up
  // with the registered phase.
  always_comb begin
    w_ltfs_nxt = '0;
    for (int k = 0; k < N_WAYS; k++) begin
      unique case (w_phase_nxt)
        BRINGUP: w_ltfs_nxt[k] = (c_BU_W'(k) < w_bu_way_nxt) ? LT_RED : LT_OFF;
        GREEN:   w_ltfs_nxt[k] = (c_AW'(k) == w_active_nxt) ? LT_GRN : LT_RED;
        YELLOW:  w_ltfs_nxt[k] = (c_AW'(k) == w_active_nxt) ? LT_YEL : LT_RED;
        ALLRED:  w_ltfs_nxt[k] = LT_RED;
        FLASH:   w_ltfs_nxt[k] = w_flash_off_nxt ? LT_OFF : LT_YEL;
        default: w_ltfs_nxt[k] = LT_OFF;
      endcase
    end
  end

  assign bus.ltfs       = r_ltfs;
  assign bus.phase      = r_phase;
  assign bus.active_way = r_active;

endmodule : traffic_phase_ctrl
`default_nettype wire

// File: tb/tb_traffic_phase_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_traffic_phase_ctrl
// Brief    : Directed and randomized bench against a timestamp-based model.
// Revision : 1.0
// ============================================================================
module tb_traffic_phase_ctrl;
  import traffic_pkg::*;

  localparam int N  = 4;
  localparam int TS = 7;
  localparam int TG = 10;
  localparam int TY = 3;
  localparam int TA = 2;
  localparam int TE = 5;
  localparam int FH = 4;
  localparam int AW = $clog2(N);

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  traffic_phase_ctrl_if #(.N_WAYS(N)) bus ();

  traffic_phase_ctrl #(
    .N_WAYS(N), .T_STAGGER(TS), .T_GREEN(TG), .T_YELLOW(TY),
    .T_ALLRED(TA), .T_EXT(TE), .FLASH_HALF(FH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int scen  = 0;
  bit saw2  = 1'b0;

  // Model: phase plus the edge number it was entered on; durations are
  // derived from edge arithmetic rather than counters.
  int          n_edge  = 0;
  int          t_entry = 0;
  phase_e      m_phase = BRINGUP;
  logic [AW-1:0] m_active = '0;
  bit          m_ext   = 1'b0;

  function automatic void model_reset();
    n_edge   = 0;
    t_entry  = 0;
    m_phase  = BRINGUP;
    m_active = '0;
    m_ext    = 1'b0;
  endfunction

  function automatic void enter(input phase_e p);
    m_phase = p;
    t_entry = n_edge;
    m_ext   = 1'b0;
  endfunction

  function automatic int pick(input int cur, input logic [N-1:0] elig, input logic [N-1:0] pref);
    for (int d = 1; d < N; d++)
      if (elig[(cur + d) % N] && pref[(cur + d) % N]) return (cur + d) % N;
    for (int d = 1; d <= N; d++)
      if (elig[(cur + d) % N]) return (cur + d) % N;
    return -1;
  endfunction

  function automatic void model_step();
    int el;
    int w;
    n_edge++;
    el = n_edge - t_entry;
    case (m_phase)
      BRINGUP: if (n_edge == 1 + N * TS) begin m_active = '0; enter(GREEN); end
      GREEN: begin
        if (bus.attention) enter(FLASH);
        else if (bus.force_reds[m_active]) enter(YELLOW);
        else begin
          if (bus.preset_adds[m_active]) m_ext = 1'b1;
          if (el == (m_ext ? TG + TE : TG)) enter(YELLOW);
        end
      end
      YELLOW: begin
        if (bus.attention) enter(FLASH);
        else if (el == TY) enter(ALLRED);
      end
      ALLRED: begin
        if (bus.attention) enter(FLASH);
        else if (el >= TA) begin
          w = pick(int'(m_active), ~bus.force_reds, bus.preferentials);
          if (w >= 0) begin m_active = AW'(w); enter(GREEN); end
        end
      end
      default: if (!bus.attention) enter(ALLRED);
    endcase
  endfunction

  function automatic light_t exp_light(input int k);
    case (m_phase)
      BRINGUP: return (n_edge >= 1 + k * TS) ? LT_RED : LT_OFF;
      GREEN:   return (AW'(k) == m_active) ? LT_GRN : LT_RED;
      YELLOW:  return (AW'(k) == m_active) ? LT_YEL : LT_RED;
      ALLRED:  return LT_RED;
      default: return ((((n_edge - t_entry) / FH) % 2) == 0) ? LT_YEL : LT_OFF;
    endcase
  endfunction

  always @(posedge clk) if (rst_n) model_step();

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s scen %0d edge %0d: got %0d expected %0d", nm, scen, n_edge, act, exp);
    end
  endtask

  task automatic pin_l(input int e, input string nm, input int w, input light_t l);
    if (n_edge == e) check(nm, int'(bus.ltfs[w]), int'(l));
  endtask

  task automatic pin_all(input int e, input string nm, input light_t l);
    if (n_edge == e) for (int k = 0; k < N; k++) check(nm, int'(bus.ltfs[k]), int'(l));
  endtask

  task automatic pin_a(input int e, input string nm, input int a);
    if (n_edge == e) check(nm, int'(bus.active_way), a);
  endtask

  // Hand-computed timestamps for the directed scenarios.
  task automatic pins();
    case (scen)
      1: begin
        pin_l(1, "bu_w0", 0, LT_RED);   pin_l(1, "bu_w1_off", 1, LT_OFF);
        pin_l(7, "bu_w1_off7", 1, LT_OFF); pin_l(8, "bu_w1", 1, LT_RED);
        pin_l(15, "bu_w2", 2, LT_RED);  pin_l(21, "bu_w3_off", 3, LT_OFF);
        pin_l(22, "bu_w3", 3, LT_RED);  pin_l(28, "bu_w0_red28", 0, LT_RED);
        pin_l(29, "g0_start", 0, LT_GRN); pin_l(38, "g0_end", 0, LT_GRN);
        pin_l(39, "y0_start", 0, LT_YEL); pin_l(41, "y0_end", 0, LT_YEL);
        pin_all(42, "ar_42", LT_RED);   pin_all(43, "ar_43", LT_RED);
        pin_l(44, "g1_start", 1, LT_GRN); pin_a(44, "act_44", 1);
      end
      2: begin
        pin_l(43, "ext_g_43", 0, LT_GRN); pin_l(44, "ext_y_44", 0, LT_YEL);
      end
      3: begin
        pin_l(59, "pref_g3", 3, LT_GRN); pin_a(59, "pref_act3", 3);
        pin_l(74, "rr_g0", 0, LT_GRN);   pin_a(74, "rr_act0", 0);
      end
      4: begin
        pin_all(33, "fl_y33", LT_YEL); pin_all(36, "fl_y36", LT_YEL);
        pin_all(37, "fl_o37", LT_OFF); pin_all(40, "fl_o40", LT_OFF);
        pin_all(41, "fl_y41", LT_YEL); pin_all(45, "fl_ar45", LT_RED);
        pin_all(46, "fl_ar46", LT_RED); pin_l(47, "fl_g1", 1, LT_GRN);
        pin_a(47, "fl_act1", 1);
      end
      5: begin
        pin_l(29, "frc_g0", 0, LT_GRN); pin_l(30, "frc_cut", 0, LT_YEL);
        pin_all(33, "frc_ar33", LT_RED); pin_all(79, "frc_ar79", LT_RED);
        pin_l(81, "frc_g1", 1, LT_GRN); pin_l(92, "frc_y1", 1, LT_YEL);
      end
      default: ;
    endcase
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      for (int k = 0; k < N; k++) check("ltfs_way", int'(bus.ltfs[k]), int'(exp_light(k)));
      check("phase", int'(bus.phase), int'(m_phase));
      check("active_way", int'(bus.active_way), int'(m_active));
      if (scen == 3 && bus.ltfs[2] == LT_GRN) saw2 = 1'b1;
      pins();
    end
  end

  task automatic start(input int s, input logic [N-1:0] frc);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    bus.attention     = 1'b0;
    bus.preset_adds   = '0;
    bus.preferentials = '0;
    bus.force_reds    = frc;
    scen = s;
    saw2 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_until(input int n);
    int budget;
    budget = 2000;
    while (n_edge < n && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (n_edge < n) begin
      tests++;
      fails++;
      $display("FAIL wait_until scen %0d: reached edge %0d required %0d", scen, n_edge, n);
    end
  endtask

  initial begin
    bus.attention     = 1'b0;
    bus.preset_adds   = '0;
    bus.force_reds    = '0;
    bus.preferentials = '0;
    model_reset();

    start(1, '0);
    wait_until(50);

    start(2, '0);
    wait_until(31); bus.preset_adds = 4'b0001;
    wait_until(32); bus.preset_adds = 4'b0000;
    wait_until(35); bus.preset_adds = 4'b0001;
    wait_until(36); bus.preset_adds = 4'b0000;
    wait_until(60);

    start(3, '0);
    wait_until(44);
    bus.preferentials = 4'b1000;
    bus.force_reds    = 4'b0100;
    wait_until(100);
    check("way2_never_green", int'(saw2), 0);

    start(4, '0);
    wait_until(32); bus.attention = 1'b1;
    wait_until(44); bus.attention = 1'b0;
    wait_until(60);

    start(5, 4'b1111);
    wait_until(80); bus.force_reds = '0;
    wait_until(92);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_ltfs", int'(bus.ltfs), 0);
    check("rst_phase", int'(bus.phase), 0);
    check("rst_active", int'(bus.active_way), 0);

    start(6, '0);
    for (int c = 0; c < 3000; c++) begin
      logic [N-1:0] v_frc;
      @(negedge clk);
      bus.preset_adds = ($urandom_range(0, 3) == 0) ? (N'($urandom) & N'($urandom)) : '0;
      if ($urandom_range(0, 19) == 0) begin
        v_frc = bus.force_reds;
        v_frc[$urandom_range(0, N - 1)] = ~v_frc[$urandom_range(0, N - 1)];
        bus.force_reds = v_frc;
      end
      if ($urandom_range(0, 9) == 0) bus.preferentials = N'($urandom);
      if ($urandom_range(0, 119) == 0) bus.attention = ~bus.attention;
      if ($urandom_range(0, 999) == 0) begin
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_traffic_phase_ctrl
`default_nettype wire
